// File: rtl/rr_arb_4_if.sv
// Request/grant bundle between requesters and the rr_arb_4 arbiter.
interface rr_arb_4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, timeout
  );
endinterface

// File: rtl/rr_arb_4.sv
// Four-requester round-robin arbiter with hold-time limit and a one-cycle
// dead gap between owners; grants are produced by a one-hot decoder.
module dec_1_4 (
  input  logic       e,
  input  logic [1:0] s,
  output logic [3:0] y
);
  always_comb begin
    y = '0;
    if (e) y[s] = 1'b1;
  end
endmodule

module rr_arb_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  rr_arb_4_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       timeout_q, timeout_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       release_now;
  logic       busy;

  // Rotating first-set scan starting at ptr.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + i[1:0];
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign release_now = bus.done || !bus.req[gnt_id_q] || (cnt_q == 8'(HOLD_MAX));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_id_d = winner;
          cnt_d    = 8'd1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d     = gnt_id_q + 2'd1;
          // Timeout flagged only when the hold limit alone forced release.
          timeout_d = !bus.done && bus.req[gnt_id_q];
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gnt_id_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy        = (state_q == GRANT);
  assign bus.busy    = busy;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.timeout = timeout_q;

  dec_1_4 u_dec (
    .e (busy),
    .s (gnt_id_q),
    .y (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arb_4.sv
// Directed bench for rr_arb_4: per-cycle vector table plus reset and HOLD_MAX=1 sequences.
module tb_rr_arb_4;

  logic clk;
  logic rst_b;

  rr_arb_4_if ifa ();
  rr_arb_4_if ifb ();

  rr_arb_4 #(.HOLD_MAX(8)) u_dut_a (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (ifa)
  );

  rr_arb_4 #(.HOLD_MAX(1)) u_dut_b (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input string nm, input logic [3:0] rq, input logic dn,
                     input logic [3:0] g, input logic [1:0] id, input logic b,
                     input logic t);
    vec_t v;
    v.name = nm; v.req = rq; v.done = dn; v.gnt = g; v.id = id; v.busy = b; v.to = t;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pack_a();
    return {7'd0, ifa.gnt, ifa.gnt_id, ifa.busy, ifa.timeout};
  endfunction

  function automatic logic [15:0] pack_b();
    return {7'd0, ifb.gnt, ifb.gnt_id, ifb.busy, ifb.timeout};
  endfunction

  initial begin
    // Rotation with done on each grant's first cycle
    add("rot_g0",   4'hF, 0, 4'b0001, 2'd0, 1, 0);
    add("rot_gap0", 4'hF, 1, 4'b0000, 2'd0, 0, 0);
    add("rot_idl0", 4'hF, 0, 4'b0000, 2'd0, 0, 0);
    add("rot_g1",   4'hF, 0, 4'b0010, 2'd1, 1, 0);
    add("rot_gap1", 4'hF, 1, 4'b0000, 2'd1, 0, 0);
    add("rot_idl1", 4'hF, 0, 4'b0000, 2'd1, 0, 0);
    add("rot_g2",   4'hF, 0, 4'b0100, 2'd2, 1, 0);
    add("rot_gap2", 4'hF, 1, 4'b0000, 2'd2, 0, 0);
    add("rot_idl2", 4'hF, 0, 4'b0000, 2'd2, 0, 0);
    add("rot_g3",   4'hF, 0, 4'b1000, 2'd3, 1, 0);
    add("rot_gap3", 4'hF, 1, 4'b0000, 2'd3, 0, 0);
    add("rot_idl3", 4'hF, 0, 4'b0000, 2'd3, 0, 0);
    add("rot_wrap", 4'hF, 0, 4'b0001, 2'd0, 1, 0);
    add("rot_gapw", 4'hF, 1, 4'b0000, 2'd0, 0, 0);
    add("rot_idlw", 4'h0, 0, 4'b0000, 2'd0, 0, 0);
    // Skip: ptr=1, req=1001
    add("skip_g3",   4'h9, 0, 4'b1000, 2'd3, 1, 0);
    add("skip_gap3", 4'h9, 1, 4'b0000, 2'd3, 0, 0);
    add("skip_idl3", 4'h9, 0, 4'b0000, 2'd3, 0, 0);
    add("skip_g0",   4'h9, 0, 4'b0001, 2'd0, 1, 0);
    add("skip_gap0", 4'h9, 1, 4'b0000, 2'd0, 0, 0);
    add("skip_idl0", 4'h9, 0, 4'b0000, 2'd0, 0, 0);
    add("skip_g3b",  4'h9, 0, 4'b1000, 2'd3, 1, 0);
    add("skip_drop", 4'h0, 0, 4'b0000, 2'd3, 0, 0);
    add("skip_idle", 4'h0, 0, 4'b0000, 2'd3, 0, 0);
    // Timeout: req=0100 held for HOLD_MAX=8
    add("to_g1", 4'h4, 0, 4'b0100, 2'd2, 1, 0);
    for (int i = 2; i <= 8; i++) add($sformatf("to_g%0d", i), 4'h4, 0, 4'b0100, 2'd2, 1, 0);
    add("to_gap",   4'h4, 0, 4'b0000, 2'd2, 0, 1);
    add("to_idle",  4'h4, 0, 4'b0000, 2'd2, 0, 0);
    add("to_regnt", 4'h4, 0, 4'b0100, 2'd2, 1, 0);
    // Request drop after 3 cycles
    add("drop_c2",   4'h4, 0, 4'b0100, 2'd2, 1, 0);
    add("drop_c3",   4'h4, 0, 4'b0100, 2'd2, 1, 0);
    add("drop_gap",  4'h0, 0, 4'b0000, 2'd2, 0, 0);
    add("drop_idle", 4'h0, 0, 4'b0000, 2'd2, 0, 0);
    add("drop_ptr3", 4'hF, 0, 4'b1000, 2'd3, 1, 0);
    // done coincides with cnt==HOLD_MAX
    for (int i = 2; i <= 8; i++) add($sformatf("sim_g%0d", i), 4'hF, 0, 4'b1000, 2'd3, 1, 0);
    add("sim_gap",   4'hF, 1, 4'b0000, 2'd3, 0, 0);
    add("sim_idle",  4'h0, 0, 4'b0000, 2'd3, 0, 0);
    add("sim_idle2", 4'h0, 0, 4'b0000, 2'd3, 0, 0);

    ifa.req = '0; ifa.done = 1'b0;
    ifb.req = '0; ifb.done = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", pack_a(), 16'h0000);
    chk("reset_b", pack_b(), 16'h0000);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      ifa.req  = vecs[i].req;
      ifa.done = vecs[i].done;
      @(posedge clk);
      #1;
      chk(vecs[i].name, pack_a(),
          {7'd0, vecs[i].gnt, vecs[i].id, vecs[i].busy, vecs[i].to});
    end

    // Reset mid-grant with ptr moved to 1, then first grant goes to requester 0
    ifa.req = 4'hF; ifa.done = 1'b0;
    @(posedge clk); #1;
    chk("mr_g0", pack_a(), {7'd0, 4'b0001, 2'd0, 1'b1, 1'b0});
    ifa.done = 1'b1;
    @(posedge clk); #1;
    ifa.done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mr_g1", pack_a(), {7'd0, 4'b0010, 2'd1, 1'b1, 1'b0});
    #2;
    rst_b = 1'b0;
    #1;
    chk("mr_async", pack_a(), 16'h0000);
    @(posedge clk); #1;
    chk("mr_held", pack_a(), 16'h0000);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("mr_first", pack_a(), {7'd0, 4'b0001, 2'd0, 1'b1, 1'b0});
    ifa.req = '0;

    // HOLD_MAX=1: each owner takes 3 cycles (grant, gap+timeout, idle)
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifb.req = 4'hF;
    for (int k = 0; k < 15; k++) begin
      logic [3:0] eg;
      logic [1:0] eid;
      int         ph;
      ph  = k % 3;
      eid = 2'((k / 3) % 4);
      eg  = (ph == 0) ? (4'b0001 << eid) : 4'b0000;
      @(posedge clk); #1;
      chk($sformatf("h1_cyc%0d", k), pack_b(),
          {7'd0, eg, eid, (ph == 0), (ph == 1)});
    end
    ifb.req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb_4.md
# rr_arb_4

Four-requester round-robin arbiter that shares a single resource (bus slot or functional unit) between requesters 0..3. It sequences grant ownership through a small FSM with a hold-time limit. It drives the team's `dec_1_4` one-hot decoder with enable = `busy` and select = `gnt_id`, so at most one grant line is ever high. A one-cycle dead gap between owners guarantees break-before-make.

## Interface
- `HOLD_MAX`, default 8: maximum cycles one requester may hold the grant. Legal range 1..255; hold counter is 8 bits wide.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_b`  input  1: asynchronous, active-low reset.
- `req`  input  4: request lines, bit i = requester i. Level-sensitive and sampled on rising edges.
- `done`  input  1: current owner releases the grant. Ignored unless in GRANT.
- `gnt`  output  4: one-hot grant, equal to `dec_1_4(e=busy, s=gnt_id)`. All zero when not busy.
- `gnt_id`  output  2: index of the current or last owner.
- `busy`  output  1: high while in GRANT.
- `timeout`  output  1: one-cycle pulse on the cycle after a grant is revoked by `HOLD_MAX`.

## Operation
- States: IDLE, GRANT, GAP.
- Reset (`rst_b`=0, asynchronous):
  - state=IDLE, `ptr`=0, `cnt`=0, `gnt_id`=0, `busy`=0, `gnt`=0000, `timeout`=0.
- IDLE:
  - If `req`≠0, choose the first set bit scanning `ptr`, `ptr`+1, ... modulo 4.
  - Load `gnt_id`=winner and `cnt`=1, then go to GRANT.
  - If `req`=0, stay in IDLE.
- GRANT: the owner keeps the grant while `req[gnt_id]`=1, `done`=0 and `cnt`<`HOLD_MAX`; `cnt` increments each cycle.
- Release condition: `done`=1, or `req[gnt_id]`=0, or `cnt`==`HOLD_MAX`.
  - On release: `ptr`=`gnt_id`+1 (mod 4, wrapping 3→0), then go to GAP.
  - `timeout` is set only when the counter is the sole cause of release.
- GAP: lasts exactly one cycle with `busy`=0 and `gnt`=0000. Always goes to IDLE.
  - Arbitration therefore happens in IDLE, after GAP.
  - Minimum hand-over period: release edge → GAP → IDLE → new GRANT.
- Priority among simultaneous release causes: `done` / `req` drop take precedence over timeout in setting `timeout`. All causes take the same release path.
- Fairness: a requester that asserts `req` continuously is granted within 3 other grants.
- `ptr` updates only on release, never in IDLE. A request that vanishes before being sampled in IDLE is never granted.

## Timing
- All outputs are registered; no combinational path from `req` or `done` to `gnt`.
- Grant latency from IDLE: `req` high before edge k → `gnt` valid after edge k.
- Release latency: release condition true before edge k → `gnt`=0000 after edge k.
- Next owner: earliest grant is after edge k+2 (GAP, then the IDLE sample).
- Hold limit: with `done`=0 and `req` held, `gnt` is high for exactly `HOLD_MAX` cycles.
  - `timeout` is high for exactly the one GAP cycle.
- `HOLD_MAX`=1: every grant lasts 1 cycle. The 4-requester rotation period is 3 cycles per owner.
- Reset mid-grant: `gnt` drops to 0000 immediately (asynchronously) and `ptr` returns to 0. After `rst_b` rises, the first grant goes to the lowest-indexed requester.

## Test plan
- Reset: `rst_b`=0 while `req`=1111 and the arbiter is in GRANT → `gnt`=0000, `busy`=0 immediately. After release, requester 0 is granted first.
- Rotation: `req`=1111 held, `done` pulsed on each grant's first cycle → `gnt` sequence 0001, 0000, 0000, 0010, 0000, 0000, 0100, 0000, 0000, 1000, ..., repeating 0001 after 1000.
- Timeout: `HOLD_MAX`=8, `req`=0100, `done`=0 → `gnt`=0100 for exactly 8 cycles, then `timeout`=1 for 1 cycle. Regrant 0100 follows after IDLE.
- Skip: `ptr`=1 and `req`=1001 → `gnt`=1000 first, then 0001 after release, then 1000 again.
- Request drop: owner 2 deasserts `req[2]` after 3 cycles with `done`=0 → release, `timeout`=0, `ptr`=3.
- Simultaneous events: `done`=1 on the same cycle as `cnt`==`HOLD_MAX` → single release, `timeout`=0.
